rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Write-back arbiter and pending-write scoreboard in front of the register file's single write port. Up to NREQ producers (ALU, load unit, CSR/mul) present write requests with valid/ready handshakes. The block grants one per cycle round-robin, registers it onto the RF write port, and tracks which registers still have an issued, uncommitted write so issue logic can stall on RAW hazards.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
DATA_W, 32, register width (matches WORD_WIDTH)
ADDR_W, 5, register address width (matches RF_ADDR_WIDTH); 2^ADDR_W registers

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  bit i: requester i has a write pending
req_ready  out  NREQ  bit i: requester i granted this cycle
req_addr  in  NREQ*ADDR_W  requester i dest at [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
sb_set  in  1  issue stage marks a destination as pending
sb_set_addr  in  ADDR_W  destination being marked
rf_we  out  1  RF write enable (registered)
rf_waddr  out  ADDR_W  RF write address (registered)
rf_wdata  out  DATA_W  RF write data (registered)
sb_pending  out  2^ADDR_W  bit r set: register r has an outstanding write
grant_id  out  $clog2(NREQ)  index of last granted requester (registered)

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_waddr=0, rf_wdata=0, sb_pending=0, grant_id=0, priority pointer ptr=0. Outputs take effect immediately, not at the next edge.
- Arbitration (combinational): scan req_valid from ptr upward, wrapping modulo NREQ. The first set bit is the winner. req_ready is one-hot on the winner, all zero if no valid.
- req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Transfer: a transfer occurs when req_valid[i] && req_ready[i]. At most one transfer per cycle. The RF never back-pressures.
- Pointer: on a transfer from i, ptr <= (i+1) mod NREQ. With no transfer, ptr holds. A requester kept valid is served at least once every NREQ cycles.
- Output stage, 1-cycle latency. On the transfer edge:
  - rf_waddr <= winner addr, rf_wdata <= winner data, grant_id <= i.
  - rf_we <= 1 unless the addr is 0.
- Addr 0 requests and idle cycles: a transfer to addr 0 handshakes normally but rf_we <= 0. With no transfer, rf_we <= 0 and rf_waddr, rf_wdata and grant_id hold.
- Scoreboard, per register r, evaluated at each edge:
  - Set: sb_set && sb_set_addr==r && r!=0.
  - Clear: a transfer this cycle with winner addr==r.
  - Set and clear on the same r in the same cycle: set wins, since a new producer was issued.
  - sb_pending[0] is constant 0. Setting an already-pending bit leaves it set; no counting.
- Timing of the clear: it occurs at the transfer edge, so in the cycle rf_we=1 the bit is already 0. Readers in that cycle obtain the data through the RF's write-to-read bypass.
- Multiple requests to the same addr on different requesters are serialized in round-robin order. The later commit overwrites the earlier one. The first commit clears the pending bit; ordering between them is the producers' responsibility.
- Register width rules: data passes unmodified, with no extension or truncation. ptr and grant_id are $clog2(NREQ) bits and wrap explicitly at NREQ, not at a power of two.
- Reset mid-transfer: an in-flight registered write is dropped (rf_we=0) and all pending bits clear. Requesters must reissue after reset.

Test Plan:
1. Reset: rst_n=0 asynchronously while rf_we=1 and sb_pending!=0 -> rf_we=0 and sb_pending=0 before the next clk edge; after release, ptr=0.
2. Single write: req_valid=3'b010, req_addr[1]=5, req_data[1]=32'hDEADBEEF -> req_ready=3'b010 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF, grant_id=1.
3. Fairness: req_valid=3'b111 held for 6 cycles from reset -> grants 0,1,2,0,1,2; req_ready always one-hot; rf_we=1 every cycle after the first.
4. Zero register: requester 0 writes addr 0, data 32'h1234 -> req_ready[0]=1; next cycle rf_we=0; sb_pending[0] stays 0.
5. Scoreboard lifecycle:
   - sb_set=1 with sb_set_addr=3 -> sb_pending[3]=1.
   - A later transfer to addr 3 -> sb_pending[3]=0 in the same cycle rf_we=1, rf_waddr=3.
   - Other bits are unchanged throughout.
6. Collision: sb_set_addr=7 and a transfer to addr 7 in the same cycle, with sb_pending[7]=1 before -> sb_pending[7]=1 after the edge; rf_we=1, rf_waddr=7 next cycle.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// pending-write scoreboard that issue logic uses to detect RAW hazards.
module rf_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int ID_W  = $clog2(NREQ),
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [NREG-1:0]          sb_pending,
  output logic [ID_W-1:0]          grant_id
);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_idx;
  logic [NREQ-1:0]   grant;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [NREG-1:0]   sb_next;

  // Round-robin scan starting at ptr; the index wraps at NREQ, not at 2**ID_W.
  always_comb begin : arb
    int idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    idx     = 0;
    grant   = '0;
    win_idx = '0;
    xfer    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!xfer && req_valid[idx]) begin
        xfer       = 1'b1;
        win_idx    = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data  = req_data[int'(win_idx)*DATA_W +: DATA_W];

  // Clear is applied before set so a same-cycle reissue keeps the bit pending.
  always_comb begin
    sb_next = sb_pending;
    if (xfer) sb_next[win_addr] = 1'b0;
    if (sb_set && (sb_set_addr != '0)) sb_next[sb_set_addr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      grant_id   <= '0;
      sb_pending <= '0;
    end else begin
      sb_pending <= sb_next;
      if (xfer) begin
        ptr      <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + ID_W'(1);
        rf_we    <= (win_addr != '0);
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        grant_id <= win_idx;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule
